// File: rtl/demux_8_reg.sv
// rtl/demux_8_reg.sv - registered 1-to-8 word distributor with direct and burst lane steering
// Optional sticky overflow flag behind DEMUX8_OVERFLOW_ERR_EN (adds overflow_err / err_clr).
module demux_8_reg #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             burst_start,
  input  logic [3:0]       burst_len,
  output logic             burst_busy,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_g,
  output logic [WIDTH-1:0] out_h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ack
`ifdef DEMUX8_OVERFLOW_ERR_EN
  ,
  output logic             overflow_err,
  input  logic             err_clr
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_BURST);

  state_t           state;
  state_t           state_n;
  logic [2:0]       ptr;
  logic [2:0]       ptr_n;
  logic [3:0]       cnt;
  logic [3:0]       cnt_n;
  logic [7:0]       valid_q;
  logic [7:0]       valid_n;
  logic [WIDTH-1:0] lane [8];

  logic [2:0]       tgt;
  logic [7:0]       tgt_onehot;
  logic             start_acc;
  logic             xfer;
  logic [3:0]       len_clamped;

  // Ready looks at the ack of the target lane in the same cycle, so a full lane
  // being drained can accept a new word without a bubble.
  always_comb begin
    tgt         = (state == BURST) ? ptr : in_select;
    tgt_onehot  = 8'b1 << tgt;
    start_acc   = (state == IDLE) && burst_start && (burst_len != 4'd0);
    in_ready    = ~start_acc & (~valid_q[tgt] | out_ack[tgt]);
    xfer        = in_valid & in_ready;
    len_clamped = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_n = BURST;
          ptr_n   = in_select;
          cnt_n   = len_clamped;
        end
      end
      BURST: begin
        if (xfer) begin
          ptr_n = ptr + 3'd1;
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A write to a lane wins over its own ack in the same cycle.
  always_comb begin
    valid_n = (valid_q & ~out_ack) | (xfer ? tgt_onehot : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= 4'd0;
      valid_q <= 8'h00;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        lane[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (xfer && tgt_onehot[i]) begin
          lane[i] <= in_data;
        end
      end
    end
  end

`ifdef DEMUX8_OVERFLOW_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (in_valid && !in_ready && !start_acc) begin
      overflow_err <= 1'b1;
    end else if (err_clr) begin
      overflow_err <= 1'b0;
    end
  end
`endif

  assign burst_busy = (state == BURST);
  assign out_valid  = valid_q;
  assign out_a      = lane[0];
  assign out_b      = lane[1];
  assign out_c      = lane[2];
  assign out_d      = lane[3];
  assign out_e      = lane[4];
  assign out_f      = lane[5];
  assign out_g      = lane[6];
  assign out_h      = lane[7];

endmodule

// File: tb/tb_demux_8_reg.sv
// tb/tb_demux_8_reg.sv - self-checking bench for demux_8_reg against a lane-level reference model
module tb_demux_8_reg;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_select;
  logic             in_valid;
  logic             in_ready;
  logic             burst_start;
  logic [3:0]       burst_len;
  logic             burst_busy;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [7:0]       out_valid;
  logic [7:0]       out_ack;
  logic             overflow_err;
  logic             err_clr;
  logic [WIDTH-1:0] lanes [8];

  int n_checks = 0;
  int n_fail   = 0;

  demux_8_reg #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_select(in_select), .in_valid(in_valid), .in_ready(in_ready),
    .burst_start(burst_start), .burst_len(burst_len), .burst_busy(burst_busy),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .out_e(out_e), .out_f(out_f), .out_g(out_g), .out_h(out_h),
    .out_valid(out_valid), .out_ack(out_ack)
`ifdef DEMUX8_OVERFLOW_ERR_EN
    , .overflow_err(overflow_err), .err_clr(err_clr)
`endif
  );

`ifndef DEMUX8_OVERFLOW_ERR_EN
  assign overflow_err = 1'b0;
`endif

  assign lanes[0] = out_a;
  assign lanes[1] = out_b;
  assign lanes[2] = out_c;
  assign lanes[3] = out_d;
  assign lanes[4] = out_e;
  assign lanes[5] = out_f;
  assign lanes[6] = out_g;
  assign lanes[7] = out_h;

  always #5 clk = ~clk;

  // Reference model: lane contents, full flags, burst progress and the error flag.
  logic [WIDTH-1:0] m_data [8];
  logic [7:0]       m_valid;
  bit               m_busy;
  int               m_ptr;
  int               m_left;
  bit               m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_data[i] = '0;
    m_valid = 8'h00;
    m_busy  = 0;
    m_ptr   = 0;
    m_left  = 0;
    m_err   = 0;
  endtask

  function automatic bit m_start();
    return !m_busy && burst_start && (burst_len != 4'd0);
  endfunction

  function automatic int m_tgt();
    return m_busy ? m_ptr : int'(in_select);
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_tgt();
    return !m_start() && (!m_valid[t] || out_ack[t]);
  endfunction

  // One clock: the model consumes the inputs present before the edge.
  task automatic tick();
    bit s, r, x;
    int t;
    s = m_start();
    t = m_tgt();
    r = m_ready();
    x = in_valid && r;
    @(posedge clk);
    m_valid = m_valid & ~out_ack;
    if (x) begin
      m_data[t]  = in_data;
      m_valid[t] = 1'b1;
      if (m_busy) begin
        m_ptr  = (m_ptr + 1) % 8;
        m_left = m_left - 1;
        if (m_left == 0) m_busy = 0;
      end
    end
    if (s) begin
      m_busy = 1;
      m_ptr  = int'(in_select);
      m_left = (int'(burst_len) > MAX_BURST) ? MAX_BURST : int'(burst_len);
    end
`ifdef DEMUX8_OVERFLOW_ERR_EN
    if (in_valid && !r && !s) m_err = 1;
    else if (err_clr) m_err = 0;
`endif
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_data     = '0;
    in_select   = 3'd0;
    burst_start = 1'b0;
    burst_len   = 4'd0;
    out_ack     = 8'h00;
    err_clr     = 1'b0;
  endtask

  task automatic drain_all();
    idle_inputs();
    out_ack = 8'hFF;
    tick();
    out_ack = 8'h00;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h exp %h", out_valid, 8'h00); end
    n_checks++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", burst_busy); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (lanes[i] !== '0) begin n_fail++; $display("FAIL reset_lane%0d got %h exp 0", i, lanes[i]); end
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    n_checks++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", overflow_err); end
  endtask

  task automatic test_direct();
    idle_inputs();
    in_select = 3'd3;
    in_data   = 32'hDEADBEEF;
    in_valid  = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL direct_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL direct_data got %h exp DEADBEEF", out_d); end
    n_checks++;
    if (out_valid !== 8'h08) begin n_fail++; $display("FAIL direct_valid got %h exp 08", out_valid); end
  endtask

  task automatic test_stall_release();
    in_select = 3'd3;
    in_data   = 32'h12345678;
    in_valid  = 1'b1;
    out_ack   = 8'h00;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got %b exp 0", in_ready); end
    tick();
    n_checks++;
    if (out_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stall_hold got %h exp DEADBEEF", out_d); end
    out_ack = 8'h08;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %b exp 1", in_ready); end
    tick();
    idle_inputs();
    n_checks++;
    if (out_d !== 32'h12345678) begin n_fail++; $display("FAIL release_data got %h exp 12345678", out_d); end
    n_checks++;
    if (out_valid[3] !== 1'b1) begin n_fail++; $display("FAIL release_valid got %b exp 1", out_valid[3]); end
  endtask

  task automatic test_burst_wrap();
    drain_all();
    burst_start = 1'b1;
    in_select   = 3'd6;
    burst_len   = 4'd4;
    n_checks++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_pre got %b exp 0", burst_busy); end
    tick();
    burst_start = 1'b0;
    in_select   = 3'd0;
    for (int b = 1; b <= 4; b++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(b);
      #1;
      n_checks++;
      if (burst_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_busy_beat%0d got %b exp 1", b, burst_busy); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready_beat%0d got %b exp 1", b, in_ready); end
      tick();
    end
    idle_inputs();
    n_checks++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL wrap_busy_post got %b exp 0", burst_busy); end
    n_checks++;
    if ({out_g, out_h, out_a, out_b} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      n_fail++;
      $display("FAIL wrap_data got g=%h h=%h a=%h b=%h exp 1 2 3 4", out_g, out_h, out_a, out_b);
    end
  endtask

  task automatic test_clamp_stall();
    int stalls, xfers, guard;
    drain_all();
    in_select = 3'd2;
    in_data   = 32'hAA;
    in_valid  = 1'b1;
    tick();
    idle_inputs();
    burst_start = 1'b1;
    burst_len   = 4'd15;
    in_select   = 3'd0;
    tick();
    burst_start = 1'b0;
    stalls = 0;
    xfers  = 0;
    guard  = 0;
    while (m_busy && guard < 30) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + WIDTH'(m_ptr);
      out_ack  = (m_ptr == 2 && stalls >= 2) ? 8'h04 : 8'h00;
      #1;
      n_checks++;
      if (in_ready !== m_ready()) begin n_fail++; $display("FAIL clamp_ready beat%0d got %b exp %b", xfers, in_ready, m_ready()); end
      if (m_ready()) xfers++;
      else stalls++;
      tick();
      guard++;
    end
    idle_inputs();
    n_checks++;
    if (guard >= 30) begin n_fail++; $display("FAIL clamp_timeout got %0d cycles exp < 30", guard); end
    n_checks++;
    if (xfers !== 8 || stalls !== 2) begin n_fail++; $display("FAIL clamp_counts got xfers=%0d stalls=%0d exp 8 2", xfers, stalls); end
    n_checks++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL clamp_busy got %b exp 0", burst_busy); end
    n_checks++;
    if (out_valid !== 8'hFF) begin n_fail++; $display("FAIL clamp_valid got %h exp FF", out_valid); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (lanes[i] !== 32'h100 + WIDTH'(i)) begin n_fail++; $display("FAIL clamp_lane%0d got %h exp %h", i, lanes[i], 32'h100 + i); end
    end
  endtask

  task automatic test_async_reset();
    drain_all();
    burst_start = 1'b1;
    burst_len   = 4'd5;
    in_select   = 3'd2;
    tick();
    burst_start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0DE0000 + WIDTH'(b);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL arst_valid got %h exp 00", out_valid); end
    n_checks++;
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", burst_busy); end
    n_checks++;
    if ({out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h} !== '0) begin
      n_fail++;
      $display("FAIL arst_lanes got c=%h d=%h exp 0", out_c, out_d);
    end
    idle_inputs();
    @(negedge clk);
    rst_n     = 1'b1;
    @(negedge clk);
    in_select = 3'd1;
    in_data   = 32'h0BADF00D;
    in_valid  = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (out_b !== 32'h0BADF00D || out_valid !== 8'h02) begin
      n_fail++;
      $display("FAIL arst_after got b=%h valid=%h exp 0BADF00D 02", out_b, out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(3) != 0);
      in_data     = $urandom;
      in_select   = 3'($urandom_range(7));
      burst_start = ($urandom_range(7) == 0);
      burst_len   = 4'($urandom_range(15));
      out_ack     = 8'($urandom & $urandom);
      err_clr     = ($urandom_range(7) == 0);
      #1;
      n_checks++;
      if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready cyc%0d got %b exp %b", c, in_ready, m_ready()); end
      tick();
      n_checks++;
      if (out_valid !== m_valid || burst_busy !== m_busy || overflow_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc%0d got valid=%h busy=%b err=%b exp %h %b %b",
                 c, out_valid, burst_busy, overflow_err, m_valid, m_busy, m_err);
      end
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (lanes[i] !== m_data[i]) begin n_fail++; $display("FAIL rand_lane%0d cyc%0d got %h exp %h", i, c, lanes[i], m_data[i]); end
      end
    end
    idle_inputs();
  endtask

`ifdef DEMUX8_OVERFLOW_ERR_EN
  task automatic test_overflow();
    drain_all();
    err_clr = 1'b1;
    tick();
    err_clr   = 1'b0;
    in_select = 3'd5;
    in_data   = 32'h55;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow_err); end
    tick();
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_hold got %b exp 1", overflow_err); end
    err_clr = 1'b1;
    tick();
    n_checks++;
    if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", overflow_err); end
    in_valid = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", overflow_err); end
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_direct();
    test_stall_release();
    test_burst_wrap();
    test_clamp_stall();
    test_async_reset();
`ifdef DEMUX8_OVERFLOW_ERR_EN
    test_overflow();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
